// File: rtl/iter_shifter.sv
// Bit-serial shifter: accepts one word, shifts it one bit per clock by a
// variable amount (left, right logical or right arithmetic), then holds the result.
module iter_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_ctrl,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_count;
  logic               r_ctrl;
  logic               r_arith;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_accept;
  logic               w_fill;
  logic [WIDTH-1:0]   w_shifted;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state; a zero amount still spends one cycle in SHIFT (without
  // shifting) so the result latency is max(amount,1) for every request.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_n = S_SHIFT;
      S_SHIFT: if (r_count <= SHAMT_W'(1)) w_state_n = S_DONE;
      S_DONE:  if (out_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // One-bit shift of the data register in the captured direction
  always_comb begin
    w_fill    = r_arith & r_data[WIDTH-1];
    w_shifted = r_data;
    if (r_ctrl) begin
      w_shifted = {w_fill, r_data[WIDTH-1:1]};
    end else begin
      w_shifted = {r_data[WIDTH-2:0], 1'b0};
    end
  end

  // Datapath: capture on accept, then shift/decrement while in SHIFT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
      r_ctrl  <= 1'b0;
      r_arith <= 1'b0;
    end else if (w_accept) begin
      r_data  <= in_data;
      r_count <= in_amt;
      r_ctrl  <= in_ctrl;
      r_arith <= in_arith;
    end else if ((r_state == S_SHIFT) && (r_count != '0)) begin
      r_data  <= w_shifted;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

  // Handshake/status flags registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_n == S_IDLE);
      r_out_valid <= (w_state_n == S_DONE);
      r_busy      <= (w_state_n != S_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_data;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter: shifts, latency, backpressure, reset.
module tb_iter_shifter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int          BUDGET  = 100;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_ctrl;
  logic [SHAMT_W-1:0] in_amt;
  logic               in_arith;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               busy;

  int checks;
  int errors;

  iter_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_amt    (in_amt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at a negedge and hold it through the accepting edge
  task automatic send(input logic [WIDTH-1:0] d, input logic c,
                      input logic [SHAMT_W-1:0] a, input logic ar);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    in_data  = d;
    in_ctrl  = c;
    in_amt   = a;
    in_arith = ar;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid is seen
  task automatic wait_valid(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    in_ctrl = 1'b0;
    in_amt = 5'd3;
    in_arith = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h, want 1 0 0 00000000",
               in_ready, out_valid, busy, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_accept: busy=%b in_ready=%b, want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_left1();
    int lat;
    bit to;
    send(32'd9, 1'b0, 5'd1, 1'b0);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 1 || out_data !== 32'd18) begin
      errors++;
      $display("FAIL left1: timeout=%0b lat=%0d data=%h, want lat=1 data=00000012", to, lat, out_data);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    pop();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_pop: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_right1();
    int lat;
    bit to;
    send(32'd5, 1'b1, 5'd1, 1'b0);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 1 || out_data !== 32'd2) begin
      errors++;
      $display("FAIL right1: timeout=%0b lat=%0d data=%h, want lat=1 data=00000002", to, lat, out_data);
    end
    pop();
    send(32'h9EAB_389A, 1'b0, 5'd1, 1'b0);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 1 || out_data !== 32'h3D56_7134) begin
      errors++;
      $display("FAIL left1_msb: timeout=%0b lat=%0d data=%h, want lat=1 data=3d567134", to, lat, out_data);
    end
    pop();
  endtask

  task automatic test_arith();
    int lat;
    bit to;
    send(32'h9EAB_389A, 1'b1, 5'd4, 1'b1);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 4 || out_data !== 32'hF9EA_B389) begin
      errors++;
      $display("FAIL sra4: timeout=%0b lat=%0d data=%h, want lat=4 data=f9eab389", to, lat, out_data);
    end
    pop();
    send(32'h9EAB_389A, 1'b1, 5'd4, 1'b0);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 4 || out_data !== 32'h09EA_B389) begin
      errors++;
      $display("FAIL srl4: timeout=%0b lat=%0d data=%h, want lat=4 data=09eab389", to, lat, out_data);
    end
    pop();
    send(32'h9EAB_389A, 1'b0, 5'd4, 1'b1);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 4 || out_data !== 32'hEAB3_89A0) begin
      errors++;
      $display("FAIL sll4_arith_ignored: timeout=%0b lat=%0d data=%h, want lat=4 data=eab389a0",
               to, lat, out_data);
    end
    pop();
  endtask

  task automatic test_boundary();
    int lat;
    bit to;
    send(32'd1, 1'b0, 5'd31, 1'b0);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 31 || out_data !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll31: timeout=%0b lat=%0d data=%h, want lat=31 data=80000000", to, lat, out_data);
    end
    pop();
    send(32'h8000_0000, 1'b1, 5'd31, 1'b1);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 31 || out_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sra31: timeout=%0b lat=%0d data=%h, want lat=31 data=ffffffff", to, lat, out_data);
    end
    pop();
    send(32'hDEAD_BEEF, 1'b1, 5'd0, 1'b1);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 1 || out_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL amt0: timeout=%0b lat=%0d data=%h, want lat=1 data=deadbeef", to, lat, out_data);
    end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    send(32'h1234_5678, 1'b0, 5'd8, 1'b0);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 8 || out_data !== 32'h3456_7800) begin
      errors++;
      $display("FAIL bp_result: timeout=%0b lat=%0d data=%h, want lat=8 data=34567800", to, lat, out_data);
    end
    @(negedge clk);
    in_data  = 32'd3;
    in_ctrl  = 1'b0;
    in_amt   = 5'd2;
    in_arith = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h3456_7800 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b data=%h in_ready=%b, want 1 34567800 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 2 || out_data !== 32'd12) begin
      errors++;
      $display("FAIL bp_second: timeout=%0b lat=%0d data=%h, want lat=2 data=0000000c", to, lat, out_data);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    send(32'h0000_FFFF, 1'b0, 5'd20, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b busy=%b in_ready=%b data=%h, want 0 0 1 00000000",
               out_valid, busy, in_ready, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    send(32'd9, 1'b0, 5'd1, 1'b0);
    wait_valid(lat, to);
    checks++;
    if (to || lat !== 1 || out_data !== 32'd18) begin
      errors++;
      $display("FAIL post_reset: timeout=%0b lat=%0d data=%h, want lat=1 data=00000012", to, lat, out_data);
    end
    pop();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_left1();
    test_right1();
    test_arith();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
